csi_rx_clock_mon: RTL and testbench

Parametrised, multi-channel successor to the single-lane CSI-2 Rx byte-clock detector. It monitors NUM_CH external byte clocks from a single free-running reference clock. For each channel it holds that channel's ISERDES reset until the clock has toggled enough times, and it releases reset while the clock runs. On clock loss it re-asserts reset, enforces a holdoff period, and then re-acquires. Per-channel loss status (sticky flag, event pulse, saturating counter) is exposed for CSR/debug. It sits between the CSI Rx PHY clock inputs and the per-camera ISERDES/lane-aligner resets.

---
 rtl/csi_rx_clock_mon.sv | 150 +++++++++++++++
 tb/tb_csi_rx_clock_mon.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_clock_mon.sv
// rtl/csi_rx_clock_mon.sv - multi-channel byte-clock presence monitor driving per-channel ISERDES resets
// Each ext_clock is sampled as data on ref_clock; a per-channel FSM gates reset_out on observed activity.
module csi_rx_clock_mon #(
  parameter int NUM_CH         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_TOGGLES   = 6,
  parameter int LOSS_CYCLES    = 200,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                    ref_clock,
  input  logic                    reset_in,
  input  logic [NUM_CH-1:0]       ext_clock,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       status_clear,
  output logic [NUM_CH-1:0]       reset_out,
  output logic [NUM_CH-1:0]       clk_locked,
  output logic [NUM_CH-1:0]       clk_lost_sticky,
  output logic [NUM_CH-1:0]       lost_pulse,
  output logic [NUM_CH*CNT_W-1:0] loss_count
);

  localparam int TOG_W  = $clog2(LOCK_TOGGLES + 1);
  localparam int IDLE_W = $clog2(LOSS_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(LOCK_TOGGLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(LOSS_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOSS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_HOLDOFF
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [TOG_W-1:0]       tog_cnt;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   rst_q;
    logic                   locked_q;
    logic                   sticky_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   toggle;
    logic                   loss_hit;
    logic [IDLE_W-1:0]      idle_nxt;
    logic [CNT_W-1:0]       cnt_inc;

    assign toggle   = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign idle_nxt = toggle ? '0 :
                      (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);
    // Fires on the cycle the idle count would reach LOSS_CYCLES, not on every saturated cycle.
    assign loss_hit = !toggle && (idle_cnt == IDLE_LAST);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge ref_clock) begin
      if (reset_in) begin
        state    <= ST_IDLE;
        sync_q   <= '0;
        hist_q   <= 1'b0;
        tog_cnt  <= '0;
        idle_cnt <= '0;
        hold_cnt <= '0;
        rst_q    <= 1'b1;
        locked_q <= 1'b0;
        sticky_q <= 1'b0;
        pulse_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_clock[i]};
        hist_q  <= sync_q[SYNC_STAGES-1];
        pulse_q <= 1'b0;
        if (status_clear[i]) begin
          sticky_q <= 1'b0;
          cnt_q    <= '0;
        end
        if (!enable[i]) begin
          state    <= ST_IDLE;
          rst_q    <= 1'b1;
          locked_q <= 1'b0;
          tog_cnt  <= '0;
          idle_cnt <= '0;
          hold_cnt <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              state    <= ST_ACQUIRE;
              tog_cnt  <= '0;
              idle_cnt <= '0;
            end
            ST_ACQUIRE: begin
              idle_cnt <= idle_nxt;
              if (toggle) begin
                if (tog_cnt == TOG_LAST) begin
                  state    <= ST_LOCKED;
                  rst_q    <= 1'b0;
                  locked_q <= 1'b1;
                  tog_cnt  <= '0;
                end else begin
                  tog_cnt <= tog_cnt + TOG_W'(1);
                end
              end else if (loss_hit) begin
                tog_cnt <= '0;
              end
            end
            ST_LOCKED: begin
              idle_cnt <= idle_nxt;
              if (loss_hit) begin
                state    <= ST_HOLDOFF;
                rst_q    <= 1'b1;
                locked_q <= 1'b0;
                pulse_q  <= 1'b1;
                sticky_q <= 1'b1;
                cnt_q    <= status_clear[i] ? CNT_W'(1) : cnt_inc;
                idle_cnt <= '0;
                hold_cnt <= '0;
              end
            end
            ST_HOLDOFF: begin
              if (hold_cnt == HOLD_LAST) begin
                state    <= ST_ACQUIRE;
                hold_cnt <= '0;
                tog_cnt  <= '0;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end

    assign reset_out[i]                  = rst_q;
    assign clk_locked[i]                 = locked_q;
    assign clk_lost_sticky[i]            = sticky_q;
    assign lost_pulse[i]                 = pulse_q;
    assign loss_count[i*CNT_W +: CNT_W]  = cnt_q;
  end

endmodule

// File: tb/tb_csi_rx_clock_mon.sv
// tb/tb_csi_rx_clock_mon.sv - scoreboard bench for csi_rx_clock_mon
// Expected lock/loss edges are queued with their predicted ref_clock cycle when stimulus is driven.
module tb_csi_rx_clock_mon;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int LAT = 3;              // SYNC_STAGES + history flop
  localparam int LOSS_LAT = LAT + 200; // drive of last toggle to loss edge
  localparam int K_LOCK = 0;
  localparam int K_LOSS = 1;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  logic              ref_clock = 1'b0;
  logic              reset_in = 1'b1;
  logic [NCH-1:0]    ext_r = '0;
  logic [NCH-1:0]    enable = '0;
  logic [NCH-1:0]    status_clear = '0;
  logic [NCH-1:0]    reset_out;
  logic [NCH-1:0]    clk_locked;
  logic [NCH-1:0]    clk_lost_sticky;
  logic [NCH-1:0]    lost_pulse;
  logic [NCH*CW-1:0] loss_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int per[NCH];
  int ph[NCH];
  int last_tog[NCH];
  ev_t sb_q[$];
  logic [NCH-1:0] prev_rst = '1;
  logic [NCH-1:0] prev_lost = '0;

  csi_rx_clock_mon #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .LOCK_TOGGLES(6), .LOSS_CYCLES(200),
    .HOLDOFF_CYCLES(16), .CNT_W(CW)
  ) dut (
    .ref_clock(ref_clock), .reset_in(reset_in), .ext_clock(ext_r), .enable(enable),
    .status_clear(status_clear), .reset_out(reset_out), .clk_locked(clk_locked),
    .clk_lost_sticky(clk_lost_sticky), .lost_pulse(lost_pulse), .loss_count(loss_count)
  );

  always #5 ref_clock = ~ref_clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int kind, input int t);
    sb_q.push_back('{c, kind, t});
  endtask

  task automatic sb_match(input int c, input int kind);
    int idx = -1;
    for (int i = 0; i < sb_q.size(); i++)
      if (idx < 0 && sb_q[i].ch == c && sb_q[i].kind == kind) idx = i;
    if (idx < 0) begin
      check($sformatf("sb_unexpected_%s_ch%0d", kind == K_LOCK ? "lock" : "loss", c), cyc, -1);
    end else begin
      check($sformatf("sb_%s_cycle_ch%0d", kind == K_LOCK ? "lock" : "loss", c), cyc, sb_q[idx].cyc);
      sb_q.delete(idx);
    end
  endtask

  always @(negedge ref_clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (!reset_in) begin
        if (prev_rst[c] && !reset_out[c]) sb_match(c, K_LOCK);
        if (!prev_lost[c] && lost_pulse[c]) sb_match(c, K_LOSS);
        if (prev_lost[c]) check($sformatf("pulse_len_ch%0d", c), lost_pulse[c], 0);
      end
    end
    prev_rst  = reset_out;
    prev_lost = lost_pulse;
  end

  // One ref_clock cycle; background channels toggle every per[c] cycles.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge ref_clock);
      #1;
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        if (per[c] != 0) begin
          ph[c]++;
          if (ph[c] >= per[c]) begin
            ph[c] = 0;
            ext_r[c] = ~ext_r[c];
            last_tog[c] = cyc;
          end
        end
      end
    end
  endtask

  task automatic toggle(input int c);
    ext_r[c] = ~ext_r[c];
    last_tog[c] = cyc;
  endtask

  task automatic lock_ch(input int c, input int period);
    for (int j = 1; j <= 6; j++) begin
      step(period);
      toggle(c);
      if (j == 6) push(c, K_LOCK, cyc + LAT);
    end
    step(period);
  endtask

  task automatic lose_ch(input int c, input bit clr, output int p);
    p = last_tog[c] + LOSS_LAT;
    push(c, K_LOSS, p);
    while (cyc < p - 1) step(1);
    check("pre_loss_rst", reset_out[c], 0);
    status_clear[c] = clr;
    step(1);
    status_clear = '0;
  endtask

  function automatic int cnt_of(input int c);
    return int'(loss_count[c*CW +: CW]);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p;
    for (int c = 0; c < NCH; c++) begin
      per[c] = 0;
      ph[c] = 0;
      last_tog[c] = 0;
    end

    step(3);
    check("rst_reset_out", reset_out, 4'hF);
    check("rst_locked", clk_locked, 0);
    check("rst_sticky", clk_lost_sticky, 0);
    check("rst_pulse", lost_pulse, 0);
    check("rst_count", loss_count, 0);
    reset_in = 1'b0;
    step(2);

    // Acquire on ch0 with period-4 toggles, ch1 static.
    enable = 4'b0001;
    lock_ch(0, 4);
    check("acq_locked", clk_locked, 4'b0001);
    check("acq_reset_out", reset_out, 4'b1110);

    // Loss on ch0, then toggles every cycle straight through holdoff.
    lose_ch(0, 1'b0, p);
    check("loss_rst", reset_out[0], 1);
    check("loss_locked", clk_locked[0], 0);
    check("loss_sticky", clk_lost_sticky[0], 1);
    check("loss_count1", cnt_of(0), 1);
    for (int j = 0; j < 20; j++) begin
      toggle(0);
      if (j == 19) push(0, K_LOCK, cyc + LAT);
      step(1);
    end
    step(4);
    check("relock", clk_locked[0], 1);
    per[0] = 3;
    ph[0] = 0;

    // Glitch rejection on ch1: 3 toggles, long gap, then 6 toggles.
    enable[1] = 1'b1;
    step(2);
    for (int j = 0; j < 3; j++) begin
      toggle(1);
      step(4);
    end
    step(210);
    for (int j = 0; j < 5; j++) begin
      toggle(1);
      step(4);
    end
    check("glitch_nolock", clk_locked[1], 0);
    toggle(1);
    push(1, K_LOCK, cyc + LAT);
    step(4);
    check("glitch_lock", clk_locked[1], 1);
    check("glitch_sticky", clk_lost_sticky[1], 0);
    per[1] = 4;
    ph[1] = 0;

    // Saturating count and clear priority on ch2.
    enable[2] = 1'b1;
    step(2);
    for (int n = 1; n <= 6; n++) begin
      lock_ch(2, 2);
      lose_ch(2, n == 6, p);
      check("sat_sticky", clk_lost_sticky[2], 1);
      check($sformatf("sat_count_%0d", n), cnt_of(2), (n == 6) ? 1 : ((n > 3) ? 3 : n));
      if (n != 6) step(17);
    end
    status_clear[2] = 1'b1;
    step(1);
    status_clear = '0;
    check("clr_sticky", clk_lost_sticky[2], 0);
    check("clr_count", cnt_of(2), 0);

    // Enable drop while locked.
    enable[1] = 1'b0;
    per[1] = 0;
    step(1);
    check("dis_rst", reset_out[1], 1);
    check("dis_locked", clk_locked[1], 0);
    check("dis_pulse", lost_pulse[1], 0);
    step(5);
    check("dis_sticky", clk_lost_sticky[1], 0);

    // Reset during holdoff.
    per[0] = 0;
    lose_ch(0, 1'b0, p);
    check("loss_count2", cnt_of(0), 2);
    step(5);
    reset_in = 1'b1;
    enable = '0;
    step(1);
    check("mid_reset_out", reset_out, 4'hF);
    check("mid_locked", clk_locked, 0);
    check("mid_sticky", clk_lost_sticky, 0);
    check("mid_pulse", lost_pulse, 0);
    check("mid_count", loss_count, 0);
    reset_in = 1'b0;
    step(2);

    // Independent channels with periods 2, 4, 8 and one stopped.
    enable = 4'hF;
    per[0] = 2; per[1] = 4; per[2] = 8; per[3] = 0;
    for (int c = 0; c < NCH; c++) ph[c] = 0;
    push(0, K_LOCK, cyc + 12 + LAT);
    push(1, K_LOCK, cyc + 24 + LAT);
    push(2, K_LOCK, cyc + 48 + LAT);
    step(60);
    check("ind_locked", clk_locked, 4'b0111);
    check("ind_reset_out", reset_out, 4'b1000);
    per[1] = 0;
    lose_ch(1, 1'b0, p);
    step(5);
    check("ind_locked2", clk_locked, 4'b0101);
    check("ind_reset_out2", reset_out, 4'b1010);
    check("ind_sticky", clk_lost_sticky, 4'b0010);
    check("ind_count", loss_count, 8'h04);

    step(2);
    check("sb_pending", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
